// File: rtl/fetch_prefetch_if.sv
// Signal bundle of the fetch stage: redirect input, instruction-memory request/response
// channels and the {pc, insn} delivery channel towards decode.
interface fetch_prefetch_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              redirect_valid_i;
    logic [AWIDTH-1:0] redirect_pc_i;

    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [AWIDTH-1:0] imem_req_addr_o;

    logic              imem_rsp_valid_i;
    logic [DWIDTH-1:0] imem_rsp_data_i;

    logic              insn_valid_o;
    logic              insn_ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;

    // The fetch stage itself.
    modport master (
        input  redirect_valid_i, redirect_pc_i,
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i, imem_rsp_data_i,
        output insn_valid_o, pc_o, insn_o,
        input  insn_ready_i
    );

    // Its surroundings: branch unit, instruction memory and decode.
    modport slave (
        output redirect_valid_i, redirect_pc_i,
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i, imem_rsp_data_i,
        input  insn_valid_o, pc_o, insn_o,
        output insn_ready_i
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: credit-limited in-order word requests, DEPTH-entry prefetch queue
// filled by in-order responses, and redirect that flushes the queue and drops stale responses.
module fetch_prefetch #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int                DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_prefetch_if.master      bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Queue slots are reserved at request accept (tag written) and filled at response.
    // Filled slots are always contiguous from the head, so fill/tail indices derive from counts.
    logic [AWIDTH-1:0] fetch_pc;
    logic [PW-1:0]     head_ptr;
    logic [CW-1:0]     occupancy;          // filled, not yet popped
    logic [CW-1:0]     live_outstanding;   // accepted requests whose response will fill a slot
    logic [CW-1:0]     drop_cnt;           // responses still owed for requests killed by redirect

    logic [AWIDTH-1:0] tag_mem  [DEPTH];
    logic [DWIDTH-1:0] data_mem [DEPTH];

    logic          redirect;
    logic          credit_ok;
    logic          req_valid;
    logic          req_fire;
    logic          insn_valid;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_fill;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] tail_idx;
    logic          unused_addr_bits;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned
    // and infer a latch.
    always_comb begin
        redirect   = bus.redirect_valid_i;
        credit_ok  = 1'b0;
        if ((occupancy + live_outstanding < DEPTH_C) &&
            (drop_cnt + live_outstanding < DEPTH_C)) begin
            credit_ok = 1'b1;
        end
        req_valid  = !rst && !redirect && credit_ok;
        req_fire   = req_valid && bus.imem_req_ready_i;
        insn_valid = !redirect && (occupancy != '0);
        pop        = insn_valid && bus.insn_ready_i;
        rsp_drop   = bus.imem_rsp_valid_i && (drop_cnt != '0);
        rsp_fill   = bus.imem_rsp_valid_i && (drop_cnt == '0);
        fill_idx   = head_ptr + occupancy[PW-1:0];
        tail_idx   = fill_idx + live_outstanding[PW-1:0];
    end

    always_comb begin
        bus.imem_req_valid_o = req_valid;
        bus.imem_req_addr_o  = {fetch_pc[AWIDTH-1:2], 2'b00};
        bus.insn_valid_o     = insn_valid;
        bus.pc_o             = '0;
        bus.insn_o           = '0;
        if (insn_valid) begin
            bus.pc_o   = tag_mem[head_ptr];
            bus.insn_o = data_mem[head_ptr];
        end
    end

    // Low address bits are always forced to zero on the way out.
    assign unused_addr_bits = ^{fetch_pc[1:0], bus.redirect_pc_i[1:0]};

    // NOTE: sequential state is updated with non-blocking assignments only, so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc         <= BASEADDR;
            head_ptr         <= '0;
            occupancy        <= '0;
            live_outstanding <= '0;
            drop_cnt         <= '0;
        end else if (redirect) begin
            // Every response still owed, minus the one arriving now, is stale.
            fetch_pc         <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            head_ptr         <= '0;
            occupancy        <= '0;
            live_outstanding <= '0;
            drop_cnt         <= drop_cnt + live_outstanding - CW'(bus.imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + AWIDTH'(4);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            occupancy        <= occupancy + CW'(rsp_fill) - CW'(pop);
            live_outstanding <= live_outstanding + CW'(req_fire) - CW'(rsp_fill);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // NOTE: the slot storage has no reset; a slot is only read once the counters say it was
    // written, and the counters themselves are reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tail_idx] <= bus.imem_req_addr_o;
        end
        if (rsp_fill && !redirect) begin
            data_mem[fill_idx] <= bus.imem_rsp_data_i;
        end
    end

    // A response nobody asked for means the memory broke the one-per-request contract.
    assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid_i |-> (live_outstanding != '0 || drop_cnt != '0));

    // Reserved slots plus dropped-but-owed responses stay within the queue/credit budget.
    assert property (@(posedge clk) disable iff (rst)
        (occupancy + live_outstanding <= DEPTH_C) && (drop_cnt + live_outstanding <= DEPTH_C));
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a vector table for streaming/backpressure plus hand
// sequences for redirect, address wrap, async reset and stale-response dropping.
module tb_fetch_prefetch;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] KEY   = 32'hC0DE_5A5A;   // memory returns addr ^ KEY
    localparam int          NVEC  = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_prefetch_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    fetch_prefetch #(
        .DWIDTH(DW), .AWIDTH(AW), .BASEADDR(BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        dr;     // decode ready
        logic        rv;     // expected imem_req_valid_o
        logic [31:0] addr;   // expected imem_req_addr_o
        logic        iv;     // expected insn_valid_o
        logic [31:0] pc;     // expected pc_o when iv
    } vec_t;

    mreq_t       mq[$];
    vec_t        vt[NVEC];
    int          cyc;
    int          mem_lat;
    logic        mem_ready;
    logic        dec_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        o_req_valid;
    logic        o_insn_valid;
    logic [31:0] o_addr;
    logic [31:0] o_pc;
    logic [31:0] o_insn;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dr, input logic rv, input logic [31:0] a,
                                input logic iv, input logic [31:0] p);
        vec_t v;
        v.dr = dr; v.rv = rv; v.addr = a; v.iv = iv; v.pc = p;
        return v;
    endfunction

    task automatic sample();
        o_req_valid  = bus.imem_req_valid_o;
        o_addr       = bus.imem_req_addr_o;
        o_insn_valid = bus.insn_valid_o;
        o_pc         = bus.pc_o;
        o_insn       = bus.insn_o;
    endtask

    // Called at a negedge: drive inputs, sample outputs, update the memory model, advance a cycle.
    task automatic tick();
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = redir_pc;
        bus.imem_req_ready_i = mem_ready;
        bus.insn_ready_i     = dec_ready;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mq[0].addr ^ KEY;
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = '0;
        end
        #1;
        sample();
        if (bus.imem_rsp_valid_i) void'(mq.pop_front());
        if (o_req_valid && mem_ready) mq.push_back('{addr: o_addr, due: cyc + mem_lat});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        sample();
        check({tag, " req_valid"},  32'(o_req_valid), 32'd0);
        check({tag, " insn_valid"}, 32'(o_insn_valid), 32'd0);
        check({tag, " pc"},         o_pc, 32'd0);
        check({tag, " insn"},       o_insn, 32'd0);
        check({tag, " addr"},       o_addr, BASE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        mem_lat = 1; mem_ready = 1'b1; dec_ready = 1'b1; redir = 1'b0; redir_pc = '0;
        bus.redirect_valid_i = 1'b0; bus.redirect_pc_i = '0;
        bus.imem_req_ready_i = 1'b0; bus.insn_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0; bus.imem_rsp_data_i = '0;

        // Streaming with latency 1, then 10 cycles of decode backpressure and release.
        vt[0] = mk(1'b1, 1'b1, BASE + 32'h00, 1'b0, 32'h0);
        vt[1] = mk(1'b1, 1'b1, BASE + 32'h04, 1'b0, 32'h0);
        vt[2] = mk(1'b1, 1'b1, BASE + 32'h08, 1'b1, BASE + 32'h00);
        vt[3] = mk(1'b1, 1'b1, BASE + 32'h0C, 1'b1, BASE + 32'h04);
        vt[4] = mk(1'b1, 1'b1, BASE + 32'h10, 1'b1, BASE + 32'h08);
        vt[5] = mk(1'b1, 1'b1, BASE + 32'h14, 1'b1, BASE + 32'h0C);
        vt[6] = mk(1'b0, 1'b1, BASE + 32'h18, 1'b1, BASE + 32'h10);
        vt[7] = mk(1'b0, 1'b1, BASE + 32'h1C, 1'b1, BASE + 32'h10);
        for (int i = 8; i < 16; i++) vt[i] = mk(1'b0, 1'b0, BASE + 32'h20, 1'b1, BASE + 32'h10);
        vt[16] = mk(1'b1, 1'b0, BASE + 32'h20, 1'b1, BASE + 32'h10);
        vt[17] = mk(1'b1, 1'b1, BASE + 32'h20, 1'b1, BASE + 32'h14);
        vt[18] = mk(1'b1, 1'b1, BASE + 32'h24, 1'b1, BASE + 32'h18);
        vt[19] = mk(1'b1, 1'b1, BASE + 32'h28, 1'b1, BASE + 32'h1C);
        vt[20] = mk(1'b1, 1'b1, BASE + 32'h2C, 1'b1, BASE + 32'h20);
        vt[21] = mk(1'b1, 1'b1, BASE + 32'h30, 1'b1, BASE + 32'h24);

        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 1;

        for (int i = 0; i < NVEC; i++) begin
            dec_ready = vt[i].dr;
            tick();
            check($sformatf("vec%0d req_valid", i + 1), 32'(o_req_valid), 32'(vt[i].rv));
            check($sformatf("vec%0d addr", i + 1), o_addr, vt[i].addr);
            check($sformatf("vec%0d insn_valid", i + 1), 32'(o_insn_valid), 32'(vt[i].iv));
            if (vt[i].iv) begin
                check($sformatf("vec%0d pc", i + 1), o_pc, vt[i].pc);
                check($sformatf("vec%0d insn", i + 1), o_insn, vt[i].pc ^ KEY);
            end
        end

        // Redirect coinciding with a response and a would-be pop.
        dec_ready = 1'b1;
        redir = 1'b1; redir_pc = 32'h0000_2000;
        tick();
        redir = 1'b0;
        check("redir_rsp_pop insn_valid", 32'(o_insn_valid), 32'd0);
        check("redir_rsp_pop req_valid", 32'(o_req_valid), 32'd0);
        tick();
        check("after_redir req_valid", 32'(o_req_valid), 32'd1);
        check("after_redir addr", o_addr, 32'h0000_2000);
        check("after_redir queue empty", 32'(o_insn_valid), 32'd0);
        tick();
        check("after_redir+1 insn_valid", 32'(o_insn_valid), 32'd0);
        check("after_redir+1 addr", o_addr, 32'h0000_2004);
        tick();
        check("after_redir+2 insn_valid", 32'(o_insn_valid), 32'd1);
        check("after_redir+2 pc", o_pc, 32'h0000_2000);
        check("after_redir+2 insn", o_insn, 32'h0000_2000 ^ KEY);

        // Redirect near the top of the address space: addresses wrap to zero.
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        tick();
        redir = 1'b0;
        check("wrap redirect req_valid", 32'(o_req_valid), 32'd0);
        tick();
        check("wrap addr0", o_addr, 32'hFFFF_FFF8);
        check("wrap req_valid0", 32'(o_req_valid), 32'd1);
        tick();
        check("wrap addr1", o_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap addr2", o_addr, 32'h0000_0000);
        check("wrap pc0", o_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap pc1", o_pc, 32'hFFFF_FFFC);
        check("wrap addr3", o_addr, 32'h0000_0004);
        tick();
        check("wrap pc2", o_pc, 32'h0000_0000);
        check("wrap insn2", o_insn, KEY);

        // Let the queue fill partway, then assert reset between clock edges.
        dec_ready = 1'b0;
        tick();
        check("pre-reset insn_valid", 32'(o_insn_valid), 32'd1);
        check("pre-reset pc", o_pc, 32'h0000_0004);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async reset");
        mq.delete();
        mem_lat = 4;
        dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 1;

        // Latency 4: three requests in flight when a misaligned redirect arrives.
        tick();
        check("restart req_valid", 32'(o_req_valid), 32'd1);
        check("restart addr", o_addr, BASE);
        tick();
        check("lat4 addr1", o_addr, BASE + 32'h4);
        tick();
        check("lat4 addr2", o_addr, BASE + 32'h8);
        redir = 1'b1; redir_pc = 32'h0100_0103;
        tick();
        redir = 1'b0;
        check("lat4 redirect req_valid", 32'(o_req_valid), 32'd0);
        tick();
        check("lat4 new req_valid", 32'(o_req_valid), 32'd1);
        check("lat4 new addr", o_addr, 32'h0100_0100);
        check("lat4 c5 insn_valid", 32'(o_insn_valid), 32'd0);
        for (int c = 6; c <= 9; c++) begin
            tick();
            check($sformatf("lat4 c%0d insn_valid (stale dropped)", c), 32'(o_insn_valid), 32'd0);
        end
        tick();
        check("lat4 first insn_valid", 32'(o_insn_valid), 32'd1);
        check("lat4 first pc", o_pc, 32'h0100_0100);
        check("lat4 first insn", o_insn, 32'h0100_0100 ^ KEY);
        check("lat4 credit stall", 32'(o_req_valid), 32'd0);
        tick();
        check("lat4 second pc", o_pc, 32'h0100_0104);
        check("lat4 credit resume", 32'(o_req_valid), 32'd1);
        check("lat4 resume addr", o_addr, 32'h0100_0110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
